// File: rtl/operand_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_feeder_pkg
// Description : Shared constants and FSM state encoding for the operand
//               bit feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_feeder_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/operand_bit_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_bit_feeder_if
// Description : Operand-pair input stream plus the two serial bit streams.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_bit_feeder_if
    import operand_feeder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) ();

    logic [2*WIDTH-1:0] s_op_tdata;
    logic               s_op_tvalid;
    logic               s_op_tready;

    logic               m_a_tdata;
    logic               m_a_tvalid;
    logic               m_a_tready;
    logic               m_a_tlast;

    logic               m_b_tdata;
    logic               m_b_tvalid;
    logic               m_b_tready;
    logic               m_b_tlast;

    logic               busy;

    modport slave (
        input  s_op_tdata, s_op_tvalid, m_a_tready, m_b_tready,
        output s_op_tready, m_a_tdata, m_a_tvalid, m_a_tlast,
               m_b_tdata, m_b_tvalid, m_b_tlast, busy
    );

    modport master (
        output s_op_tdata, s_op_tvalid, m_a_tready, m_b_tready,
        input  s_op_tready, m_a_tdata, m_a_tvalid, m_a_tlast,
               m_b_tdata, m_b_tvalid, m_b_tlast, busy
    );

endinterface
`default_nettype wire

// File: rtl/operand_bit_feeder_bit_channel.sv
`default_nettype none
// ============================================================================
// Module      : bit_channel
// Description : LSB-first serialiser for one operand with its own beat
//               counter and valid/last handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_channel
    import operand_feeder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             arst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_tready,
    output logic                  o_tdata,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    output logic                  o_finished
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_valid;
    logic               r_done;
    logic               w_beat;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);
    assign w_beat = r_valid && i_tready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
        end else if (w_beat) begin
            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            // Counter parks on the last index rather than wrapping.
            if (w_last) begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_tdata    = r_shift[0];
    assign o_tvalid   = r_valid;
    assign o_tlast    = r_valid && w_last;
    // Includes the finishing beat itself so the FSM can leave SEND on that edge.
    assign o_finished = r_done || (w_beat && w_last);

endmodule
`default_nettype wire

// File: rtl/operand_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : operand_bit_feeder
// Description : Accepts an operand pair and streams A and B bit-serially on
//               two independent channels toward a half-adder stage.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bit_feeder
    import operand_feeder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            arst,
    operand_bit_feeder_if.slave  op_if
);

    feeder_state_t r_state;
    feeder_state_t w_state_next;
    logic          r_ready_en;
    logic          w_accept;
    logic          w_a_fin;
    logic          w_b_fin;

    // Keeps s_op_tready low until the first edge after reset release.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= IDLE;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = SEND;
            SEND:    if (w_a_fin && w_b_fin) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign op_if.s_op_tready = r_ready_en && (r_state == IDLE);
    assign w_accept          = op_if.s_op_tvalid && op_if.s_op_tready;
    assign op_if.busy        = (r_state != IDLE);

    bit_channel #(.WIDTH(WIDTH)) u_chan_a (
        .clk        (clk),
        .arst       (arst),
        .i_load     (w_accept),
        .i_data     (op_if.s_op_tdata[WIDTH-1:0]),
        .i_tready   (op_if.m_a_tready),
        .o_tdata    (op_if.m_a_tdata),
        .o_tvalid   (op_if.m_a_tvalid),
        .o_tlast    (op_if.m_a_tlast),
        .o_finished (w_a_fin)
    );

    bit_channel #(.WIDTH(WIDTH)) u_chan_b (
        .clk        (clk),
        .arst       (arst),
        .i_load     (w_accept),
        .i_data     (op_if.s_op_tdata[2*WIDTH-1:WIDTH]),
        .i_tready   (op_if.m_b_tready),
        .o_tdata    (op_if.m_b_tdata),
        .o_tvalid   (op_if.m_b_tvalid),
        .o_tlast    (op_if.m_b_tlast),
        .o_finished (w_b_fin)
    );

endmodule
`default_nettype wire

// File: tb/tb_operand_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_bit_feeder
// Description : Scoreboard bench for operand_bit_feeder at WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_bit_feeder;

    localparam int c_W = 4;

    logic clk  = 1'b0;
    logic arst = 1'b1;

    int errors = 0;
    int checks = 0;
    int last_a = 0;
    int last_b = 0;
    bit rand_en = 1'b0;

    // Each entry is {expected bit, expected tlast}.
    logic [1:0] q_a[$];
    logic [1:0] q_b[$];

    logic [1:0] pv = '0, pr = '0, pd = '0, pl = '0;

    operand_bit_feeder_if #(.WIDTH(c_W)) bus ();

    operand_bit_feeder #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .arst  (arst),
        .op_if (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard and stream-protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [1:0] cv, cr, cd, cl;
        logic [1:0] exp;
        cv = {bus.m_b_tvalid, bus.m_a_tvalid};
        cr = {bus.m_b_tready, bus.m_a_tready};
        cd = {bus.m_b_tdata,  bus.m_a_tdata};
        cl = {bus.m_b_tlast,  bus.m_a_tlast};
        if (arst) begin
            pv = '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (pv[ch] && !pr[ch]) begin
                    checks++;
                    if (!cv[ch] || cd[ch] !== pd[ch] || cl[ch] !== pl[ch]) begin
                        errors++;
                        $display("FAIL hold ch%0d: valid=%b data=%b last=%b, required valid=1 data=%b last=%b",
                                 ch, cv[ch], cd[ch], cl[ch], pd[ch], pl[ch]);
                    end
                end
                if (cv[ch] && cr[ch]) begin
                    checks++;
                    if ((ch == 0 && q_a.size() == 0) || (ch == 1 && q_b.size() == 0)) begin
                        errors++;
                        $display("FAIL beat ch%0d: unexpected beat data=%b last=%b, required none", ch, cd[ch], cl[ch]);
                    end else begin
                        exp = (ch == 0) ? q_a.pop_front() : q_b.pop_front();
                        if ({cd[ch], cl[ch]} !== exp) begin
                            errors++;
                            $display("FAIL beat ch%0d: data=%b last=%b, required data=%b last=%b",
                                     ch, cd[ch], cl[ch], exp[1], exp[0]);
                        end
                    end
                    if (cl[ch]) begin
                        if (ch == 0) last_a++;
                        else         last_b++;
                    end
                end
            end
            pv = cv; pr = cr; pd = cd; pl = cl;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int limit, output int cyc);
        cyc = 0;
        while (!bus.s_op_tready && cyc < limit) begin
            step();
            cyc++;
        end
        checks++;
        if (!bus.s_op_tready) begin
            errors++;
            $display("FAIL ready_timeout: s_op_tready=0 after %0d cycles, required 1", cyc);
        end
    endtask

    task automatic accept_pair(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        bus.s_op_tdata  = {b, a};
        bus.s_op_tvalid = 1'b1;
        for (int i = 0; i < c_W; i++) begin
            q_a.push_back({a[i], 1'(i == c_W - 1)});
            q_b.push_back({b[i], 1'(i == c_W - 1)});
        end
        step();
        bus.s_op_tvalid = 1'b0;
    endtask

    // Returns one cycle after the accepting edge (the first beat cycle).
    task automatic send_pair(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        int n;
        wait_ready(200, n);
        accept_pair(a, b);
    endtask

    task automatic test_reset();
        arst            = 1'b1;
        bus.s_op_tvalid = 1'b0;
        bus.s_op_tdata  = '0;
        bus.m_a_tready  = 1'b1;
        bus.m_b_tready  = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.s_op_tready !== 1'b0) begin
            errors++; $display("FAIL reset_tready: %b, required 0", bus.s_op_tready);
        end
        checks++;
        if ({bus.m_a_tvalid, bus.m_b_tvalid} !== 2'b00) begin
            errors++; $display("FAIL reset_tvalid: %b, required 00", {bus.m_a_tvalid, bus.m_b_tvalid});
        end
        checks++;
        if ({bus.m_a_tdata, bus.m_b_tdata, bus.m_a_tlast, bus.m_b_tlast} !== 4'b0000) begin
            errors++; $display("FAIL reset_data_last: %b, required 0000",
                               {bus.m_a_tdata, bus.m_b_tdata, bus.m_a_tlast, bus.m_b_tlast});
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: %b, required 0", bus.busy);
        end
        arst = 1'b0;
        #1;
        checks++;
        if (bus.s_op_tready !== 1'b0) begin
            errors++; $display("FAIL release_tready_early: %b, required 0", bus.s_op_tready);
        end
        step();
        checks++;
        if (bus.s_op_tready !== 1'b1) begin
            errors++; $display("FAIL release_tready: %b, required 1", bus.s_op_tready);
        end
    endtask

    task automatic test_basic();
        int la = last_a;
        int lb = last_b;
        send_pair(4'b1011, 4'b0110);
        for (int k = 1; k <= c_W; k++) begin
            checks++;
            if ({bus.m_a_tvalid, bus.m_b_tvalid, bus.m_a_tlast, bus.m_b_tlast, bus.s_op_tready}
                    !== {2'b11, {2{1'(k == c_W)}}, 1'b0}) begin
                errors++;
                $display("FAIL basic_beat%0d: va/vb/la/lb/rdy=%b, required %b", k - 1,
                         {bus.m_a_tvalid, bus.m_b_tvalid, bus.m_a_tlast, bus.m_b_tlast, bus.s_op_tready},
                         {2'b11, {2{1'(k == c_W)}}, 1'b0});
            end
            if (k < c_W) step();
        end
        step();
        checks++;
        if ({bus.busy, bus.m_a_tvalid, bus.m_b_tvalid, bus.s_op_tready} !== 4'b1000) begin
            errors++; $display("FAIL basic_done: busy/va/vb/rdy=%b, required 1000",
                               {bus.busy, bus.m_a_tvalid, bus.m_b_tvalid, bus.s_op_tready});
        end
        step();
        checks++;
        if (bus.s_op_tready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_ready_cycle6: rdy=%b busy=%b, required rdy=1 busy=0",
                               bus.s_op_tready, bus.busy);
        end
        checks++;
        if (last_a - la != 1 || last_b - lb != 1) begin
            errors++; $display("FAIL basic_tlast_count: a=%0d b=%0d, required 1 1", last_a - la, last_b - lb);
        end
    endtask

    task automatic test_backpressure();
        send_pair(4'b1011, 4'b0110);
        step();
        bus.m_b_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.m_b_tvalid !== 1'b1 || bus.m_b_tdata !== 1'b1) begin
                errors++; $display("FAIL bp_stall%0d: b valid=%b data=%b, required valid=1 data=1",
                                   k, bus.m_b_tvalid, bus.m_b_tdata);
            end
            step();
        end
        bus.m_b_tready = 1'b1;
        checks++;
        if ({bus.m_a_tvalid, bus.m_b_tvalid, bus.busy} !== 3'b011) begin
            errors++; $display("FAIL bp_a_first: va/vb/busy=%b, required 011",
                               {bus.m_a_tvalid, bus.m_b_tvalid, bus.busy});
        end
        step();
        step();
        checks++;
        if ({bus.m_b_tvalid, bus.m_b_tlast, bus.busy, bus.s_op_tready} !== 4'b1110) begin
            errors++; $display("FAIL bp_b_last: vb/lb/busy/rdy=%b, required 1110",
                               {bus.m_b_tvalid, bus.m_b_tlast, bus.busy, bus.s_op_tready});
        end
        step();
        checks++;
        if ({bus.m_b_tvalid, bus.busy, bus.s_op_tready} !== 3'b010) begin
            errors++; $display("FAIL bp_done: vb/busy/rdy=%b, required 010",
                               {bus.m_b_tvalid, bus.busy, bus.s_op_tready});
        end
        step();
        checks++;
        if (bus.s_op_tready !== 1'b1) begin
            errors++; $display("FAIL bp_idle: rdy=%b, required 1", bus.s_op_tready);
        end
    endtask

    task automatic test_ignore_busy();
        int n;
        send_pair(4'h3, 4'hC);
        bus.s_op_tdata  = 8'hFF;
        bus.s_op_tvalid = 1'b1;
        wait_ready(50, n);
        checks++;
        if (n + 1 != 6) begin
            errors++; $display("FAIL ignore_accept_cycle: %0d, required 6", n + 1);
        end
        accept_pair(4'hF, 4'hF);
        wait_ready(50, n);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++; $display("FAIL ignore_drain: pending a=%0d b=%0d, required 0 0", q_a.size(), q_b.size());
        end
    endtask

    task automatic test_reset_midstream();
        int n;
        send_pair(4'hA, 4'h5);
        step();
        step();
        arst = 1'b1;
        q_a.delete();
        q_b.delete();
        #1;
        checks++;
        if ({bus.m_a_tvalid, bus.m_b_tvalid, bus.busy, bus.s_op_tready} !== 4'b0000) begin
            errors++; $display("FAIL midreset_outputs: va/vb/busy/rdy=%b, required 0000",
                               {bus.m_a_tvalid, bus.m_b_tvalid, bus.busy, bus.s_op_tready});
        end
        step();
        arst = 1'b0;
        step();
        send_pair(4'h1, 4'h8);
        checks++;
        if ({bus.m_a_tvalid, bus.m_b_tvalid, bus.m_a_tdata, bus.m_b_tdata} !== 4'b1110) begin
            errors++; $display("FAIL midreset_first_beat: va/vb/da/db=%b, required 1110",
                               {bus.m_a_tvalid, bus.m_b_tvalid, bus.m_a_tdata, bus.m_b_tdata});
        end
        wait_ready(50, n);
        checks++;
        if (n + 1 != 6) begin
            errors++; $display("FAIL midreset_pair_len: %0d, required 6", n + 1);
        end
    endtask

    task automatic test_random();
        int n;
        int la = last_a;
        int lb = last_b;
        rand_en = 1'b1;
        fork
            begin
                while (rand_en) begin
                    step();
                    bus.m_a_tready = 1'($urandom_range(0, 1));
                    bus.m_b_tready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int p = 0; p < 100; p++) begin
            send_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        wait_ready(400, n);
        rand_en = 1'b0;
        step();
        step();
        bus.m_a_tready = 1'b1;
        bus.m_b_tready = 1'b1;
        checks++;
        if (last_a - la != 100 || last_b - lb != 100) begin
            errors++; $display("FAIL random_tlast_count: a=%0d b=%0d, required 100 100", last_a - la, last_b - lb);
        end
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++; $display("FAIL random_drain: pending a=%0d b=%0d, required 0 0", q_a.size(), q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignore_busy();
        test_reset_midstream();
        test_random();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_bit_feeder.md
OPERAND_BIT_FEEDER -- requirements
Module: operand_bit_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port arst, input, 1 bit, reset, asynchronous and active-high.
REQ-004 SHALL have port s_op_tdata, input, 2*WIDTH bits, operand pair {B[WIDTH-1:0], A[WIDTH-1:0]}.
REQ-005 SHALL have port s_op_tvalid, input, 1 bit, operand pair valid.
REQ-006 SHALL have port s_op_tready, output, 1 bit, block can accept an operand pair.
REQ-007 SHALL have ports m_a_tdata / m_b_tdata, output, 1 bit each, current A / B bit to the half-adder stage.
REQ-008 SHALL have ports m_a_tvalid / m_b_tvalid, output, 1 bit each, bit stream valid.
REQ-009 SHALL have ports m_a_tready / m_b_tready, input, 1 bit each, downstream accepts the bit.
REQ-010 SHALL have ports m_a_tlast / m_b_tlast, output, 1 bit each, marks bit WIDTH-1 of the operand.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-012 SHALL run an FSM with states IDLE, SEND and DONE.
REQ-013 SHALL hold s_op_tready=1 in IDLE only, and 0 in SEND and DONE.
REQ-014 SHALL, on an s_op handshake in IDLE, register A and B, clear both bit counters and go to SEND.
REQ-015 SHALL drive m_a_tvalid/m_b_tvalid high in the cycle after the accept handshake, carrying bit 0 (LSB first).
REQ-016 SHALL give the A and B channels independent counters; each advances only on its own handshake (tvalid and tready).
REQ-017 SHALL hold tdata and tlast stable while a channel's tvalid is high and tready is low; tvalid SHALL NOT drop without a handshake.
REQ-018 SHALL assert tlast exactly when a channel's counter equals WIDTH-1.
REQ-019 SHALL deassert a channel's tvalid in the cycle after its tlast handshake; that channel then idles until the other channel finishes.
REQ-020 SHALL leave SEND for DONE once both channels have completed their tlast handshakes (same cycle or different cycles); DONE SHALL go to IDLE on the next cycle.
REQ-021 SHALL need at least WIDTH+2 cycles per operand pair with continuous tready (accept, WIDTH beats, DONE); no overlap between operand pairs.
REQ-022 SHALL ignore s_op_tvalid outside IDLE and SHALL NOT sample s_op_tdata there.
REQ-023 SHALL size each counter at $clog2(WIDTH) bits with no wrap past WIDTH-1.

Reset
REQ-024 SHALL, while arst is high, force the FSM to IDLE and drive s_op_tready=0, all m_*_tvalid=0, all m_*_tdata=0, all m_*_tlast=0, busy=0, and clear the counters and operand registers.
REQ-025 SHALL drive s_op_tready=1 from the first clk edge after arst falls.
REQ-026 SHALL drop any transfer interrupted by arst mid-stream without completing it; the first beat after reset SHALL come from a new operand pair.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=2'b00, SEND=2'b01, DONE=2'b10) and the default WIDTH constant in a shared package, operand_feeder_pkg.
REQ-028 SHALL implement each bit stream in a sub-module bit_channel (shift register, counter, tvalid/tlast logic) instantiated twice, with the top holding the FSM.

Verification (WIDTH=4 bench)
REQ-029 SHALL cover: A=4'b1011, B=4'b0110, both treadys held high -> m_a bits 1,1,0,1 and m_b bits 0,1,1,0 on consecutive cycles, tlast on beat 3, s_op_tready high again 6 cycles after accept.
REQ-030 SHALL cover: m_b_tready low for 3 cycles at beat 1 -> m_b_tdata=1 and tvalid held stable throughout, A finishes first, DONE entered only after B's tlast handshake.
REQ-031 SHALL cover: s_op_tvalid held high during SEND with a new pair 4'hF/4'hF -> not accepted until IDLE; the first pair is streamed unchanged.
REQ-032 SHALL cover: arst pulsed at beat 2 -> all tvalid=0 immediately, busy=0; the next pair A=4'h1, B=4'h8 streams from bit 0.
REQ-033 SHALL cover: random tready toggling on both channels over 100 pairs -> scoreboard matches every bit, exactly one tlast per channel per pair, no tvalid drop without a handshake.
